// File: rtl/con_bus_scheduler_if.sv
// Shared-bus handshake bundle between the load requester, the ODS drain
// logic, the chip pins and the scheduler that arbitrates between them.
interface con_bus_if #(
    parameter int DRAIN_LEN_W = 2
);
    logic                   load_req;
    logic                   load_last;
    logic                   load_ready_in;
    logic                   load_grant;
    logic                   load_beat;
    logic                   con_valid;
    logic                   con_ready;
    logic                   drain_req;
    logic [DRAIN_LEN_W-1:0] drain_len;
    logic                   drain_grant;
    logic                   drain_shift;
    logic                   drain_done;
    logic                   output_valid;
    logic                   driving_cons;

    // Requesters and pins.
    modport master (
        output load_req, load_last, load_ready_in, con_valid, drain_req, drain_len,
        input  load_grant, load_beat, con_ready, drain_grant, drain_shift,
               drain_done, output_valid, driving_cons
    );

    // Scheduler.
    modport slave (
        input  load_req, load_last, load_ready_in, con_valid, drain_req, drain_len,
        output load_grant, load_beat, con_ready, drain_grant, drain_shift,
               drain_done, output_valid, driving_cons
    );
endinterface

// File: rtl/con_bus_scheduler.sv
// Time-multiplexes the bidirectional con bus between inbound loads and
// outbound result drains, with dead turnaround cycles on every direction
// change and preemption of long loads while a drain is waiting.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | bus parked inbound, nobody granted
// LOAD      | inbound words accepted via con_valid/con_ready
// TURN_OUT  | dead cycles before the chip starts driving the pins
// DRAIN     | chip drives con_1..3, one result word per cycle
// TURN_IN   | dead cycles after the chip releases the pins
module con_bus_scheduler #(
    parameter int TURNAROUND_CYCLES = 1,
    parameter int MAX_LOAD_BURST    = 16,
    parameter int DRAIN_LEN_W       = 2
) (
    input  logic      clk,
    input  logic      rst_in,
    con_bus_if.slave  bus
);
    localparam int BW = $clog2(MAX_LOAD_BURST + 1);
    localparam int TW = $clog2(TURNAROUND_CYCLES + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_LOAD_BURST);
    localparam logic [TW-1:0] TURN_LOAD = TW'(TURNAROUND_CYCLES);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOAD     = 3'd1;
    localparam logic [2:0] ST_TURN_OUT = 3'd2;
    localparam logic [2:0] ST_DRAIN    = 3'd3;
    localparam logic [2:0] ST_TURN_IN  = 3'd4;

    logic [2:0]             state;
    logic [2:0]             state_nx;
    logic [BW-1:0]          burst_cnt;
    logic [TW-1:0]          turn_cnt;
    logic [DRAIN_LEN_W-1:0] drain_rem;
    logic                   beat;
    logic                   preempt;
    logic                   turn_end;
    logic                   drain_end;
    logic                   enter_turn_out;
    logic                   enter_turn_in;

    assign bus.con_ready    = (state == ST_LOAD) && bus.load_ready_in;
    assign beat             = bus.con_valid && bus.con_ready;
    assign bus.load_beat    = beat;
    assign bus.load_grant   = (state == ST_LOAD);
    assign bus.drain_grant  = (state == ST_TURN_OUT) || (state == ST_DRAIN);
    assign bus.drain_shift  = (state == ST_DRAIN);
    assign bus.output_valid = (state == ST_DRAIN);
    assign bus.driving_cons = (state == ST_DRAIN);
    assign bus.drain_done   = (state == ST_DRAIN) && drain_end;

    assign turn_end  = (turn_cnt == TW'(1));
    assign drain_end = (drain_rem == DRAIN_LEN_W'(1));

    // Limit counts this cycle's beat, so the beat that fills the burst also preempts.
    assign preempt = bus.drain_req &&
                     ((burst_cnt == BURST_MAX) || (beat && (burst_cnt == BURST_MAX - 1'b1)));

    assign enter_turn_out = (state_nx == ST_TURN_OUT) && (state != ST_TURN_OUT);
    assign enter_turn_in  = (state_nx == ST_TURN_IN) && (state != ST_TURN_IN);

    // Next-state decode; drain wins over load when both are requested.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (bus.drain_req)     state_nx = ST_TURN_OUT;
                else if (bus.load_req) state_nx = ST_LOAD;
            end
            ST_LOAD: begin
                if (beat && bus.load_last)         state_nx = bus.drain_req ? ST_TURN_OUT : ST_IDLE;
                else if (preempt)                  state_nx = ST_TURN_OUT;
                else if (!beat && !bus.load_req)   state_nx = ST_IDLE;
            end
            ST_TURN_OUT: if (turn_end)  state_nx = ST_DRAIN;
            ST_DRAIN:    if (drain_end) state_nx = ST_TURN_IN;
            ST_TURN_IN:  if (turn_end)  state_nx = ST_IDLE;
            default:                    state_nx = ST_IDLE;
        endcase
    end

    // State, burst counter, turnaround and drain down-counters.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            state     <= ST_IDLE;
            burst_cnt <= '0;
            turn_cnt  <= '0;
            drain_rem <= '0;
        end else begin
            state <= state_nx;

            if (state != ST_LOAD)
                burst_cnt <= '0;
            else if (beat && (burst_cnt != BURST_MAX))
                burst_cnt <= burst_cnt + 1'b1;

            if (enter_turn_out || enter_turn_in)
                turn_cnt <= TURN_LOAD;
            else if (turn_cnt != '0)
                turn_cnt <= turn_cnt - 1'b1;

            // A zero length still drains one word.
            if (enter_turn_out)
                drain_rem <= (bus.drain_len == '0) ? DRAIN_LEN_W'(1) : bus.drain_len;
            else if ((state == ST_DRAIN) && (drain_rem != '0))
                drain_rem <= drain_rem - 1'b1;
        end
    end
endmodule

// File: tb/tb_con_bus_scheduler.sv
// Bench for con_bus_scheduler: a timeline model of load/drain phases checked
// against the DUT every cycle, plus directed scenarios with literal timings.
module tb_con_bus_scheduler;
    localparam int TURN = 1;
    localparam int MAX  = 4;

    logic clk = 1'b0;
    logic rst_in;

    con_bus_if #(.DRAIN_LEN_W(2)) bus();

    con_bus_scheduler #(
        .TURNAROUND_CYCLES(TURN),
        .MAX_LOAD_BURST   (MAX),
        .DRAIN_LEN_W      (2)
    ) dut (
        .clk   (clk),
        .rst_in(rst_in),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc     = 0;
    int nchecks = 0;
    int nerr    = 0;
    bit chk_en  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic act, input logic exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model: phases as timelines ----------------
    logic m_lg, m_dg, m_drv, m_done;
    bit   m_abort;
    int   m_next;   // what happens after the current cycle: 0 idle, 1 load, 2 drain

    task automatic tick();
        @(posedge clk);
        m_abort = rst_in;
    endtask

    task automatic m_out(input logic lg, input logic dg, input logic drv, input logic dn);
        m_lg = lg; m_dg = dg; m_drv = drv; m_done = dn;
    endtask

    initial begin : model
        int len;
        int beats;
        bit beat;
        m_next  = 0;
        m_abort = 1'b0;
        m_out(0, 0, 0, 0);
        forever begin
            if (m_next == 2) begin
                len     = (bus.drain_len == 2'd0) ? 1 : int'(bus.drain_len);
                m_abort = 1'b0;
                m_out(0, 1, 0, 0);
                for (int i = 0; i < TURN; i++) if (!m_abort) tick();
                for (int b = 1; b <= len; b++)
                    if (!m_abort) begin
                        m_out(0, 1, 1, b == len);
                        tick();
                    end
                if (!m_abort) begin
                    m_out(0, 0, 0, 0);
                    for (int i = 0; i < TURN; i++) if (!m_abort) tick();
                end
                m_next = 0;
            end else if (m_next == 1) begin
                beats = 0;
                m_out(1, 0, 0, 0);
                while (m_next == 1) begin
                    tick();
                    if (m_abort) m_next = 0;
                    else begin
                        beat = bus.con_valid && bus.load_ready_in;
                        if (beat && beats < MAX) beats++;
                        if (beat && bus.load_last)            m_next = bus.drain_req ? 2 : 0;
                        else if (bus.drain_req && beats >= MAX) m_next = 2;
                        else if (!beat && !bus.load_req)        m_next = 0;
                    end
                end
            end else begin
                m_out(0, 0, 0, 0);
                tick();
                if (m_abort)            m_next = 0;
                else if (bus.drain_req) m_next = 2;
                else if (bus.load_req)  m_next = 1;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic exp_cr;
        if (chk_en) begin
            exp_cr = m_lg && bus.load_ready_in;
            check("load_grant",   bus.load_grant,   m_lg);
            check("con_ready",    bus.con_ready,    exp_cr);
            check("load_beat",    bus.load_beat,    exp_cr && bus.con_valid);
            check("drain_grant",  bus.drain_grant,  m_dg);
            check("drain_shift",  bus.drain_shift,  m_drv);
            check("output_valid", bus.output_valid, m_drv);
            check("driving_cons", bus.driving_cons, m_drv);
            check("drain_done",   bus.drain_done,   m_done);
        end
    end

    // ---------------- directed stimulus ----------------
    logic lg_l [0:23];
    logic cr_l [0:23];
    logic bt_l [0:23];
    logic dg_l [0:23];
    logic dv_l [0:23];
    logic dn_l [0:23];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rec(input int c);
        @(negedge clk);
        lg_l[c] = bus.load_grant;
        cr_l[c] = bus.con_ready;
        bt_l[c] = bus.load_beat;
        dg_l[c] = bus.drain_grant;
        dv_l[c] = bus.driving_cons;
        dn_l[c] = bus.drain_done;
    endtask

    function automatic int count(input int which, input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++)
            case (which)
                0:       if (bt_l[i] === 1'b1) n++;
                1:       if (dv_l[i] === 1'b1) n++;
                default: if (cr_l[i] === 1'b1) n++;
            endcase
        return n;
    endfunction

    task automatic drive(input logic lr, input logic ll, input logic rdy, input logic vld,
                         input logic dr, input logic [1:0] dl);
        bus.load_req = lr; bus.load_last = ll; bus.load_ready_in = rdy;
        bus.con_valid = vld; bus.drain_req = dr; bus.drain_len = dl;
    endtask

    initial begin : stim
        logic [6:0] eg, ed, en;
        rst_in = 1'b1;
        drive(0, 0, 1, 1, 0, 2'd0);
        step();
        step();
        @(negedge clk);
        check("reset_load_grant",   bus.load_grant,   1'b0);
        check("reset_con_ready",    bus.con_ready,    1'b0);
        check("reset_load_beat",    bus.load_beat,    1'b0);
        check("reset_drain_grant",  bus.drain_grant,  1'b0);
        check("reset_driving_cons", bus.driving_cons, 1'b0);
        check("reset_output_valid", bus.output_valid, 1'b0);
        check("reset_drain_done",   bus.drain_done,   1'b0);
        chk_en = 1'b1;
        step();
        rst_in = 1'b0;
        drive(0, 0, 0, 0, 0, 2'd0);
        step();

        // Basic load: five beats, last on the fifth.
        for (int c = 0; c <= 6; c++) begin
            step();
            drive(c <= 5, c == 5, 1, (c >= 1) && (c <= 5), 0, 2'd0);
            rec(c);
        end
        check_int("t1_beats", count(0, 1, 5), 5);
        check("t1_grant_c1", lg_l[1], 1'b1);
        check("t1_idle_c6",  lg_l[6], 1'b0);
        check_int("t1_no_drive", count(1, 0, 6), 0);

        // Basic drain, length 3; length change after latch ignored.
        eg = 7'b0011110;
        ed = 7'b0011100;
        en = 7'b0010000;
        for (int c = 0; c <= 6; c++) begin
            step();
            drive(0, 0, 0, 0, c <= 4, (c == 0) ? 2'd3 : 2'd1);
            rec(c);
        end
        for (int c = 0; c <= 6; c++) begin
            check("t2_drain_grant", dg_l[c], eg[c]);
            check("t2_driving",     dv_l[c], ed[c]);
            check("t2_drain_done",  dn_l[c], en[c]);
        end

        // Preemption at burst 4, resume, preempt again after a fresh 4 beats.
        for (int c = 0; c <= 19; c++) begin
            step();
            drive(c <= 18, c == 18, 1, (c >= 1) && (c <= 18),
                  ((c >= 2) && (c <= 7)) || ((c >= 10) && (c <= 15)),
                  (c < 10) ? 2'd2 : 2'd1);
            rec(c);
        end
        check_int("t3_beats_first", count(0, 1, 4), 4);
        check_int("t3_beats_gap",   count(0, 5, 9), 0);
        check("t3_ready_c5",  cr_l[5],  1'b0);
        check("t3_done_c7",   dn_l[7],  1'b1);
        check("t3_lg_c9",     lg_l[9],  1'b0);
        check("t3_lg_c10",    lg_l[10], 1'b1);
        check("t3_lg_c13",    lg_l[13], 1'b1);
        check("t3_lg_c14",    lg_l[14], 1'b0);
        check("t3_done_c15",  dn_l[15], 1'b1);
        check("t3_lg_c18",    lg_l[18], 1'b1);
        check("t3_lg_c19",    lg_l[19], 1'b0);
        check_int("t3_beats_second", count(0, 10, 18), 5);

        // Simultaneous requests; drain_len 0 gives one beat.
        for (int c = 0; c <= 6; c++) begin
            step();
            drive(c <= 5, c == 5, 1, c == 5, c <= 2, 2'd0);
            rec(c);
        end
        check("t4_drain_first", dg_l[1], 1'b1);
        check("t4_no_load_c1",  lg_l[1], 1'b0);
        check("t4_done_c2",     dn_l[2], 1'b1);
        check("t4_lg_c4",       lg_l[4], 1'b0);
        check("t4_lg_c5",       lg_l[5], 1'b1);
        check("t4_lg_c6",       lg_l[6], 1'b0);
        check_int("t4_one_beat", count(1, 1, 6), 1);

        // Backpressure, then con_valid held through a drain.
        for (int c = 0; c <= 10; c++) begin
            step();
            drive(c <= 5, c == 5, ((c >= 1) && (c <= 4)) ? logic'(c % 2 == 1) : 1'b1,
                  c >= 1, (c >= 6) && (c <= 8), 2'd1);
            rec(c);
        end
        check("t5_idle_beat",   bt_l[0], 1'b0);
        check_int("t5_beats",   count(0, 1, 4), 2);
        check("t5_stall_c2",    bt_l[2], 1'b0);
        check("t5_last_beat",   bt_l[5], 1'b1);
        check_int("t5_no_accept_drain", count(0, 6, 10), 0);
        check_int("t5_no_ready_drain",  count(2, 7, 9), 0);

        // Reset on drain beat 2 of 3, then a fresh drain.
        for (int c = 0; c <= 10; c++) begin
            step();
            rst_in = (c == 3);
            drive(0, 0, 1, 0, c <= 8, 2'd3);
            rec(c);
        end
        rst_in = 1'b0;
        check("t6_drive_c3",  dv_l[3], 1'b1);
        check("t6_drive_c4",  dv_l[4], 1'b0);
        check("t6_grant_c4",  dg_l[4], 1'b0);
        check("t6_grant_c5",  dg_l[5], 1'b1);
        check("t6_drive_c5",  dv_l[5], 1'b0);
        check("t6_drive_c6",  dv_l[6], 1'b1);
        check("t6_done_c8",   dn_l[8], 1'b1);
        check("t6_drive_c9",  dv_l[9], 1'b0);

        drive(0, 0, 0, 0, 0, 2'd0);
        repeat (3) step();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end
endmodule

// File: doc/con_bus_scheduler.md
# con_bus_scheduler

Time-multiplexes the shared bidirectional con_1/con_2/con_3 bus between the load path (input/kernel words into IDSS/KDS) and the drain path (results out of ODS). It owns bus direction (driving_cons), the inbound con_valid/con_ready handshake and outbound output_valid. It inserts dead turnaround cycles on every direction change and preempts long load bursts when results are waiting. It sits between controller_fsm (load requester), the ODS drain logic (drain requester) and the chip pins.

## Interface
- TURNAROUND_CYCLES, 1: dead cycles per direction change; legal range ≥1.
- MAX_LOAD_BURST, 16: beats a load may take while drain_req is pending before preemption; ≥1.
- DRAIN_LEN_W, 2: width of drain_len.
- clk  in  1  clock; all state updates on rising edge.
- rst_in  in  1  reset, synchronous, active-high.
- load_req  in  1  load requester wants inbound words; held until its last beat.
- load_last  in  1  qualifies the current beat as the final beat of the load.
- load_ready_in  in  1  load consumer can accept a word this cycle.
- load_grant  out  1  high while in LOAD.
- load_beat  out  1  con_valid && con_ready; one pulse per accepted word.
- con_valid  in  1  external source has a word on con_1..3.
- con_ready  out  1  (state==LOAD) && load_ready_in; combinational.
- drain_req  in  1  ODS holds results; held until drain_done.
- drain_len  in  DRAIN_LEN_W  beats in the drain; sampled at grant; 0 is treated as 1.
- drain_grant  out  1  high in TURN_OUT and DRAIN.
- drain_shift  out  1  high on every DRAIN beat (ODS shift).
- drain_done  out  1  one-cycle pulse on the last DRAIN beat.
- output_valid  out  1  high on every DRAIN beat.
- driving_cons  out  1  chip drives con_1..3; high only in DRAIN.

## Operation
- States: IDLE, LOAD, TURN_OUT, DRAIN, TURN_IN.
- Outputs are Moore decodes of state and counters, except con_ready and load_beat.
- Reset:
  - State is IDLE.
  - All counters are 0.
  - Every output is 0, including driving_cons.
- IDLE transitions:
  - drain_req → TURN_OUT. Drain has priority when both requests are present.
  - Otherwise load_req → LOAD.
  - Otherwise stay in IDLE.
- LOAD behaviour:
  - Bus is inbound.
  - burst_cnt is cleared on entry and increments on each load_beat, saturating at MAX_LOAD_BURST.
- LOAD exits:
  - Beat with load_last, drain_req high → TURN_OUT.
  - Beat with load_last, drain_req low → IDLE.
  - Beat with drain_req high and burst_cnt reaching MAX_LOAD_BURST (inclusive of this beat) → TURN_OUT. This is preemption. The load is unfinished, and load_req stays high and is re-served later.
  - drain_req high, burst_cnt already at the limit, no beat this cycle → TURN_OUT.
  - load_req drops with no beat → IDLE.
- On the LOAD→TURN_OUT or IDLE→TURN_OUT transition, drain_len is latched; a latched 0 becomes 1.
- TURN_OUT:
  - driving_cons=0, con_ready=0.
  - Lasts TURNAROUND_CYCLES cycles, then → DRAIN.
- DRAIN:
  - driving_cons=1, output_valid=1, drain_shift=1 every cycle; no backpressure.
  - Lasts exactly the latched length.
  - drain_done is asserted on the last beat, then → TURN_IN.
- TURN_IN:
  - driving_cons=0.
  - Lasts TURNAROUND_CYCLES cycles, then → IDLE.
  - drain_req is ignored here. The requester must lower it by the cycle after drain_done.
- con_valid arriving outside LOAD is never accepted; con_ready stays 0.
- drain_len changes after latching have no effect.
- rst_in mid-operation: next edge returns to IDLE with all outputs 0, even mid-DRAIN. driving_cons drops at that edge.

## Timing
- Load start latency: load_req at cycle t in IDLE → load_grant and con_ready (if load_ready_in) at t+1.
- Drain latency, from IDLE with drain_req at t:
  - TURN_OUT spans t+1 … t+TURNAROUND_CYCLES.
  - First DRAIN beat at t+1+TURNAROUND_CYCLES.
  - drain_done at t+TURNAROUND_CYCLES+len.
- Bus idle gap: driving_cons is never high in the same cycle as con_ready. At least TURNAROUND_CYCLES cycles separate any con_ready=1 cycle from any driving_cons=1 cycle, in both directions.
- Minimum drain occupancy: 2·TURNAROUND_CYCLES+len cycles from grant to IDLE.

## Test plan
- Basic load, defaults: load_req with 5 con_valid beats, load_ready_in=1, load_last on beat 5 → 5 load_beat pulses; IDLE one cycle after beat 5; driving_cons stays 0.
- Basic drain, defaults, drain_len=3 at cycle 0 → drain_grant cycles 1–4; TURN_OUT cycle 1; driving_cons/output_valid/drain_shift cycles 2–4; drain_done cycle 4; TURN_IN cycle 5; IDLE cycle 6.
- Preemption: MAX_LOAD_BURST=4, drain_req raised after load beat 1, continuous beats → con_ready drops after beat 4; drain (len 2) runs; load resumes in LOAD after TURN_IN with burst_cnt=0.
- Simultaneity: drain_req and load_req both rising in IDLE → TURN_OUT first; LOAD entered only after drain and TURN_IN. drain_len=0 gives exactly one beat.
- Backpressure: load_ready_in toggling 1,0,1,0 with con_valid=1 → load_beat only on the ready cycles; con_valid ignored in TURN_OUT/DRAIN/TURN_IN.
- Reset mid-DRAIN (beat 2 of 3) → next cycle all outputs 0, state IDLE. A following drain_req behaves as a fresh drain with full turnaround.
